// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling, 3-sample majority vote
// per bit, valid/ack output handshake with framing-error pulse and sticky overrun.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           r_state, w_next;
  logic             r_sync1, r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_scnt;
  logic [2:0]       r_bidx;
  logic [7:0]       r_shreg;
  logic             r_v7, r_v8, r_vote;
  logic [7:0]       r_data;
  logic             r_valid, r_ferr, r_ovr;

  logic w_rx_s, w_tick, w_t9, w_t15, w_vote;
  logic w_shift, w_deliver, w_ferr, w_busy;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_div == DIV_MAX);
  assign w_t9   = w_tick && (r_scnt == 4'd9);
  assign w_t15  = w_tick && (r_scnt == 4'd15);
  // Majority of the samples at ticks 7 and 8 plus the live sample at tick 9
  assign w_vote = (r_v7 & r_v8) | (r_v7 & w_rx_s) | (r_v8 & w_rx_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_rx_s) w_next = S_START;
      S_START: if (w_t15) w_next = r_vote ? S_IDLE : S_DATA;
      S_DATA:  if (w_t15 && (r_bidx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_t9) w_next = w_vote ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift   = (r_state == S_DATA) && w_t15;
    w_deliver = (r_state == S_STOP) && w_t9 && w_vote;
    w_ferr    = (r_state == S_STOP) && w_t9 && !w_vote;
    w_busy    = (r_state != S_IDLE);
  end

  // Timing counters are held at zero in IDLE so every frame starts from its falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_scnt <= '0;
      r_bidx <= '0;
    end else if (r_state == S_IDLE) begin
      r_div  <= '0;
      r_scnt <= '0;
      r_bidx <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_scnt <= r_scnt + 4'd1;
      if (r_state == S_START) r_bidx <= '0;
      else if (w_shift)       r_bidx <= r_bidx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tick && (r_scnt == 4'd7)) r_v7 <= w_rx_s;
    if (w_tick && (r_scnt == 4'd8)) r_v8 <= w_rx_s;
    if (w_t9)                       r_vote <= w_vote;
    if (w_shift)                    r_shreg <= {r_vote, r_shreg[7:1]};
  end

  // Delivery takes priority over a same-cycle ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      if (w_deliver) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
        if (r_valid && !rx_ack) r_ovr <= 1'b1;
        else if (rx_ack)        r_ovr <= 1'b0;
      end else if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_busy   = w_busy;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule
